// File: rtl/dl_seq_ctrl.sv
// rtl/dl_seq_ctrl.sv - HPS download sequencer: ROM write port, variant/DIP registers, core reset.
// The core leaves reset only after a full-length ROM image followed by a settle countdown.
module dl_seq_ctrl #(
  parameter int ROM_SIZE    = 32768,
  parameter int ROM_AW      = 15,
  parameter int HOLD_CYCLES = 16
) (
  input  logic              clk_i,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [7:0]        ioctl_index,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              rom_we,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [7:0]        rom_data,
  output logic [7:0]        mod,
  output logic [7:0]        dsw0,
  output logic [7:0]        dsw1,
  output logic              core_reset,
  output logic              dl_busy,
  output logic              rom_err
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

  state_t        state;
  logic          dl_q;
  logic          dl_is_rom;
  logic          rom_loaded;
  logic [16:0]   rom_cnt;
  logic [16:0]   cnt_next;
  logic [HW-1:0] hold_cnt;
  logic          err_next;

  logic idx_rom, idx_mod, idx_dip;
  logic start, fall, rom_window, rom_strobe, addr_ok, rom_wr, rom_ovf;

  assign idx_rom = (ioctl_index == 8'd0);
  assign idx_mod = (ioctl_index == 8'd1);
  assign idx_dip = (ioctl_index == 8'd254);

  // The edge register keeps sampling through block reset so a download that
  // is still running when reset drops is not mistaken for a fresh start.
  always_ff @(posedge clk_i) begin
    dl_q <= ioctl_download;
  end

  assign start      = ioctl_download & ~dl_q & (idx_rom | idx_mod);
  assign fall       = ~ioctl_download & dl_q;
  assign rom_window = start ? idx_rom : ((state == LOAD) & dl_is_rom);
  assign rom_strobe = ioctl_wr & ioctl_download & idx_rom & rom_window;
  assign addr_ok    = (ioctl_addr < 25'(ROM_SIZE));
  assign rom_wr     = rom_strobe & addr_ok;
  assign rom_ovf    = rom_strobe & ~addr_ok;

  always_comb begin
    cnt_next = (start && idx_rom) ? 17'd0 : rom_cnt;
    if (rom_wr && cnt_next != '1) cnt_next = cnt_next + 17'd1;
  end

  always_comb begin
    err_next = rom_err;
    if (start && idx_rom) err_next = 1'b0;
    if (rom_ovf) err_next = 1'b1;
    if (state == LOAD && fall && dl_is_rom && rom_cnt != 17'(ROM_SIZE)) err_next = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state      <= IDLE;
      rom_we     <= 1'b0;
      rom_addr   <= '0;
      rom_data   <= 8'd0;
      mod        <= 8'hFF;
      dsw0       <= 8'd0;
      dsw1       <= 8'd0;
      core_reset <= 1'b1;
      dl_busy    <= 1'b0;
      rom_err    <= 1'b0;
      rom_cnt    <= 17'd0;
      rom_loaded <= 1'b0;
      dl_is_rom  <= 1'b0;
      hold_cnt   <= '0;
    end else begin
      rom_we  <= rom_wr;
      rom_cnt <= cnt_next;
      rom_err <= err_next;
      if (rom_wr) begin
        rom_addr <= ioctl_addr[ROM_AW-1:0];
        rom_data <= ioctl_dout;
      end
      if (ioctl_wr && idx_mod) mod <= ioctl_dout;
      if (ioctl_wr && idx_dip && ioctl_addr[24:3] == 22'd0) begin
        if (ioctl_addr[2:0] == 3'd0) dsw0 <= ioctl_dout;
        if (ioctl_addr[2:0] == 3'd1) dsw1 <= ioctl_dout;
      end

      if (start) begin
        state      <= LOAD;
        dl_busy    <= 1'b1;
        core_reset <= 1'b1;
        dl_is_rom  <= idx_rom;
      end else begin
        case (state)
          LOAD: begin
            if (fall) begin
              state    <= HOLD;
              hold_cnt <= HW'(HOLD_CYCLES - 1);
              if (dl_is_rom) rom_loaded <= 1'b1;
            end
          end
          HOLD: begin
            if (hold_cnt == '0) begin
              dl_busy <= 1'b0;
              if (!rom_err && rom_loaded) begin
                state      <= RUN;
                core_reset <= 1'b0;
              end else begin
                state      <= IDLE;
                core_reset <= 1'b1;
              end
            end else begin
              hold_cnt <= hold_cnt - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
